// File: rtl/ioctl_streamer.sv
// ioctl bus driver: byte-stream downloads into ioctl writes, and ioctl reads back out as an upload stream.
// Define IOCTL_STREAM_CHECKSUM_EN to add an 8-bit running checksum output.

module ioctl_streamer #(
  parameter int unsigned WR_GAP     = 4,
  parameter int unsigned UPLOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic        cmd_upload,
  input  logic [7:0]  cmd_index,
  input  logic [24:0] cmd_len,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        ioctl_download,
  output logic        ioctl_upload,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_index,
  input  logic [7:0]  ioctl_din
`ifdef IOCTL_STREAM_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StDlWait,
    StDlStrobe,
    StDlGap,
    StUpWait,
    StUpPush,
    StEnd
  } state_e;

  state_e          state_q, state_d;
  logic [24:0]     addr_q, addr_d;
  logic [24:0]     last_q, last_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      index_q, index_d;
  logic [7:0]      mdata_q, mdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] gap_end;
  logic            is_last;
  logic            accept;

  assign is_last = (addr_q == last_q);
  assign accept  = (state_q == StIdle) && cmd_start;

  // The wait cycle after an address bump is the final gap cycle, so a streaming download
  // strobes every WR_GAP+1 cycles; after the last byte the full gap elapses before END.
  assign gap_end = is_last ? CntW'(WR_GAP) : CntW'(WR_GAP - 1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    dout_d  = dout_q;
    index_d = index_q;
    mdata_d = mdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_len == '0) begin
            state_d = StEnd;
          end else begin
            addr_d  = '0;
            last_d  = cmd_len - 25'd1;
            index_d = cmd_index;
            cnt_d   = '0;
            state_d = cmd_upload ? StUpWait : StDlWait;
          end
        end
      end
      StDlWait: begin
        if (s_valid) begin
          dout_d  = s_data;
          state_d = StDlStrobe;
        end
      end
      StDlStrobe: begin
        if (!is_last && (WR_GAP == 1)) begin
          addr_d  = addr_q + 25'd1;
          state_d = StDlWait;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StDlGap;
        end
      end
      StDlGap: begin
        if (cnt_q == gap_end) begin
          if (is_last) begin
            state_d = StEnd;
          end else begin
            addr_d  = addr_q + 25'd1;
            state_d = StDlWait;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StUpWait: begin
        // Capture only once the consumer has had UPLOAD_LAT full cycles on the new address.
        if (cnt_q == CntW'(UPLOAD_LAT)) begin
          mdata_d = ioctl_din;
          state_d = StUpPush;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StUpPush: begin
        if (m_ready) begin
          if (is_last) begin
            state_d = StEnd;
          end else begin
            addr_d  = addr_q + 25'd1;
            cnt_d   = '0;
            state_d = StUpWait;
          end
        end
      end
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      last_q  <= '0;
      dout_q  <= '0;
      index_q <= '0;
      mdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      index_q <= index_d;
      mdata_q <= mdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StEnd);
  assign s_ready        = (state_q == StDlWait);
  assign ioctl_wr       = (state_q == StDlStrobe);
  assign ioctl_download = (state_q == StDlWait) || (state_q == StDlStrobe) ||
                          (state_q == StDlGap);
  assign ioctl_upload   = (state_q == StUpWait) || (state_q == StUpPush);
  assign m_valid        = (state_q == StUpPush);
  assign m_data         = mdata_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;

`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (ioctl_wr) begin
      csum_q <= csum_q + ioctl_dout;
    end else if (m_valid && m_ready) begin
      csum_q <= csum_q + m_data;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_streamer.sv
// Bench for ioctl_streamer: directed vector table, reset corner case and randomized transfers
// checked against expected byte lists and a latency-accurate ioctl consumer.

module tb_ioctl_streamer;

  localparam int unsigned WR_GAP     = 4;
  localparam int unsigned UPLOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start, cmd_upload;
  logic [7:0]  cmd_index;
  logic [24:0] cmd_len;
  logic        busy, done;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index, ioctl_din;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  ioctl_streamer #(
    .WR_GAP     (WR_GAP),
    .UPLOAD_LAT (UPLOAD_LAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_start      (cmd_start),
    .cmd_upload     (cmd_upload),
    .cmd_index      (cmd_index),
    .cmd_len        (cmd_len),
    .busy           (busy),
    .done           (done),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .ioctl_download (ioctl_download),
    .ioctl_upload   (ioctl_upload),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_din      (ioctl_din)
`ifdef IOCTL_STREAM_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Consumer: din reflects an address UPLOAD_LAT clocks after the address changes.
  logic [7:0]  din_off = 8'h00;
  logic [24:0] apipe [UPLOAD_LAT];
  always @(posedge clk) begin
    apipe[0] <= ioctl_addr;
    for (int k = 1; k < UPLOAD_LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign ioctl_din = apipe[UPLOAD_LAT-1][7:0] + 8'h10 + din_off;

  function automatic logic [7:0] din_exp(input int i);
    return 8'(i) + 8'h10 + din_off;
  endfunction

  // Monitor: records every transfer event and counts protocol violations.
  int          wr_addr_q[$], wr_cyc_q[$], up_addr_q[$];
  logic [7:0]  wr_data_q[$], up_data_q[$];
  int          mcyc = 0, done_cnt = 0, done_cyc = 0, dl_fall_cyc = 0, act_cnt = 0, viol = 0;
  logic        prev_dl = 1'b0, prev_mv = 1'b0, prev_wr = 1'b0;
  logic [24:0] prev_addr = '0;

  always @(negedge clk) begin
    mcyc <= mcyc + 1;
    if (ioctl_wr) begin
      wr_addr_q.push_back(int'(ioctl_addr));
      wr_data_q.push_back(ioctl_dout);
      wr_cyc_q.push_back(mcyc);
    end
    if (m_valid && m_ready) begin
      up_data_q.push_back(m_data);
      up_addr_q.push_back(int'(ioctl_addr));
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= mcyc;
    end
    if (prev_dl && !ioctl_download) dl_fall_cyc <= mcyc;
    act_cnt <= act_cnt + int'(ioctl_download || ioctl_upload || ioctl_wr);
    viol <= viol + int'(ioctl_download && ioctl_upload) + int'(s_ready && !ioctl_download)
          + int'(ioctl_wr && !ioctl_download) + int'(m_valid && !ioctl_upload)
          + int'((ioctl_download || ioctl_upload) && !busy)
          + int'(prev_mv && m_valid && (ioctl_addr != prev_addr))
          + int'(prev_wr && ioctl_download && (ioctl_addr != prev_addr));
    prev_dl   <= ioctl_download;
    prev_mv   <= m_valid;
    prev_wr   <= ioctl_wr;
    prev_addr <= ioctl_addr;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       up;
    logic [7:0] idx;
    int         len;
    logic [7:0] base;
    int         step;
    int         stall_at;
    int         stall_cyc;
    int         pct;
    int         poke;
    int         exp_count;
    logic [7:0] exp_index;
    int         exp_last;
  } vec_t;

  function automatic vec_t mk(input logic up, input logic [7:0] idx, input int len,
                              input logic [7:0] base, input int step, input int stall_at,
                              input int stall_cyc, input int pct, input int poke,
                              input int exp_count, input logic [7:0] exp_index,
                              input int exp_last);
    vec_t v;
    v.up = up; v.idx = idx; v.len = len; v.base = base; v.step = step;
    v.stall_at = stall_at; v.stall_cyc = stall_cyc; v.pct = pct; v.poke = poke;
    v.exp_count = exp_count; v.exp_index = exp_index; v.exp_last = exp_last;
    return v;
  endfunction

  logic [7:0] dl_bytes [64];
  int done0, wr_base, up_base, act0, viol0, last_lat;

  task automatic load_bytes(input vec_t v);
    for (int i = 0; i < 64; i++) dl_bytes[i] = v.base + 8'(i * v.step);
  endtask

  task automatic run_xfer(input vec_t v);
    int  n, stall_left;
    bit  go, chk_stall, finished;
    done0 = done_cnt; wr_base = wr_addr_q.size(); up_base = up_data_q.size();
    act0 = act_cnt; viol0 = viol; last_lat = -1;
    cmd_upload = v.up; cmd_index = v.idx; cmd_len = 25'(v.len); cmd_start = 1'b1;
    @(posedge clk); #2;
    cmd_start = 1'b0;
    n = 0; stall_left = v.stall_cyc; chk_stall = 0; finished = 0;
    for (int cyc_i = 0; cyc_i < 4000 && !finished; cyc_i++) begin
      @(negedge clk);
      if (chk_stall) begin
        chk("stall_addr_held", ioctl_addr, v.stall_at);
        chk("stall_handshake_pending", v.up ? m_valid : s_ready, 1);
        chk_stall = 0;
      end
      if (!v.up && s_valid && s_ready) n++;
      if (v.up && m_valid && m_ready) n++;
      if (done) begin
        finished = 1;
        last_lat = cyc_i;
      end
      @(posedge clk); #2;
      if (!finished) begin
        cmd_start = (cyc_i == v.poke);
        if (cmd_start) begin
          cmd_upload = ~v.up; cmd_index = 8'hEE; cmd_len = 25'd2;
        end
        if (n == v.stall_at && stall_left > 0) begin
          go = 0;
          stall_left--;
          chk_stall = (stall_left == 0);
        end else begin
          go = ($urandom_range(99) < v.pct);
        end
        s_valid = !v.up && go && (n < v.len);
        s_data  = dl_bytes[n & 63];
        m_ready = v.up && go;
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: done not seen in 4000 cycles, required one done pulse");
    end
    cmd_start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic check_xfer(input vec_t v);
    int         n_got, last_i;
    logic [7:0] exp_b, sum;
    bit         contig;
    sum = 8'h00;
    contig = !v.up && v.pct == 100 && v.stall_cyc == 0;
    n_got = v.up ? up_data_q.size() - up_base : wr_addr_q.size() - wr_base;
    chk("xfer_count", n_got, v.exp_count);
    for (int i = 0; i < n_got && i < v.exp_count; i++) begin
      exp_b = v.up ? din_exp(i) : dl_bytes[i];
      sum = sum + exp_b;
      if (v.up) begin
        chk("up_data", up_data_q[up_base+i], exp_b);
        chk("up_addr", up_addr_q[up_base+i], i);
      end else begin
        chk("wr_data", wr_data_q[wr_base+i], exp_b);
        chk("wr_addr", wr_addr_q[wr_base+i], i);
        if (contig && i > 0)
          chk("wr_spacing", wr_cyc_q[wr_base+i] - wr_cyc_q[wr_base+i-1], WR_GAP + 1);
      end
    end
    chk("done_pulses", done_cnt - done0, 1);
    chk("index_after", ioctl_index, v.exp_index);
    chk("addr_after", ioctl_addr, v.exp_last);
    if (v.len == 0) begin
      chk("zero_len_done_latency", last_lat, 0);
      chk("zero_len_activity", act_cnt - act0, 0);
    end else if (!v.up && n_got > 0) begin
      last_i = wr_base + n_got - 1;
      chk("dout_after", ioctl_dout, dl_bytes[v.len-1]);
      chk("dl_fall_after_gap", dl_fall_cyc - wr_cyc_q[last_i], WR_GAP + 1);
      chk("done_at_dl_fall", done_cyc, dl_fall_cyc);
    end
    chk("protocol_violations", viol - viol0, 0);
`ifdef IOCTL_STREAM_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
  endtask

  vec_t vecs[$];
  vec_t rv;
  int   n_rst;
  bit   found;

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; cmd_upload = 1'b0; cmd_index = '0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

    //               up   idx    len base  stp st_at st_cy pct  poke cnt idx   last
    vecs.push_back(mk(1'b0, 8'h03, 8, 8'h00, 1, 0, 0,  100, -1, 8, 8'h03, 7));
    vecs.push_back(mk(1'b0, 8'h77, 0, 8'h00, 1, 0, 0,  100, -1, 0, 8'h03, 7));
    vecs.push_back(mk(1'b0, 8'h05, 4, 8'h30, 1, 2, 10, 100, -1, 4, 8'h05, 3));
    vecs.push_back(mk(1'b1, 8'h06, 4, 8'h00, 1, 1, 6,  100, -1, 4, 8'h06, 3));
    vecs.push_back(mk(1'b0, 8'hAA, 1, 8'hC3, 1, 0, 0,  100, -1, 1, 8'hAA, 0));
    vecs.push_back(mk(1'b1, 8'h42, 1, 8'h00, 1, 0, 0,  60,  -1, 1, 8'h42, 0));
    vecs.push_back(mk(1'b0, 8'h09, 4, 8'h80, 5, 0, 0,  70,   3, 4, 8'h09, 3));
`ifdef IOCTL_STREAM_CHECKSUM_EN
    vecs.push_back(mk(1'b0, 8'h11, 2, 8'hFF, 3, 0, 0,  100, -1, 2, 8'h11, 1));
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {busy, done, s_ready, m_valid, m_data, ioctl_download, ioctl_upload,
                          ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index}, 0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    foreach (vecs[vi]) begin
      load_bytes(vecs[vi]);
      run_xfer(vecs[vi]);
      check_xfer(vecs[vi]);
    end

    // Reset in the middle of an 8-byte download, right after byte 3 is strobed.
    for (int i = 0; i < 64; i++) dl_bytes[i] = 8'h50 + 8'(i);
    done0 = done_cnt;
    cmd_upload = 1'b0; cmd_index = 8'h21; cmd_len = 25'd8; cmd_start = 1'b1;
    @(posedge clk); #2;
    cmd_start = 1'b0; s_valid = 1'b1; s_data = dl_bytes[0];
    n_rst = 0; found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (s_valid && s_ready) n_rst++;
      if (ioctl_wr && ioctl_addr == 25'd3) found = 1;
      @(posedge clk); #2;
      s_data = dl_bytes[n_rst & 63];
    end
    chk("reset_mid_reached_byte3", found, 1);
    reset_n = 1'b0; s_valid = 1'b0;
    @(posedge clk); #2;
    chk("reset_mid_outputs", {busy, done, s_ready, m_valid, m_data, ioctl_download, ioctl_upload,
                              ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index}, 0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("reset_mid_no_done", done_cnt - done0, 0);
    rv = mk(1'b0, 8'h31, 3, 8'h60, 1, 0, 0, 100, -1, 3, 8'h31, 2);
    load_bytes(rv);
    run_xfer(rv);
    check_xfer(rv);

    // Randomized transfers against the expected byte lists.
    for (int r = 0; r < 10; r++) begin
      rv.up        = 1'($urandom_range(1));
      rv.len       = int'($urandom_range(12, 1));
      rv.idx       = 8'($urandom);
      rv.base      = 8'($urandom);
      rv.step      = int'($urandom_range(255));
      rv.stall_at  = int'($urandom_range(rv.len - 1));
      rv.stall_cyc = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(10, 6));
      rv.pct       = int'($urandom_range(100, 30));
      rv.poke      = -1;
      rv.exp_count = rv.len;
      rv.exp_index = rv.idx;
      rv.exp_last  = rv.len - 1;
      din_off      = 8'($urandom);
      load_bytes(rv);
      run_xfer(rv);
      check_xfer(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
